// File: rtl/ext_int_source.sv
// ext_int_source: queued interrupt source fed by a periodic counter and an external trigger, retired by CPU ack stores
module ext_int_source #(
  parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
  parameter int PEND_W = 4,
  parameter int GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              period_en,
  input  logic [31:0]       period,
  input  logic              trig,
  input  logic [31:0]       m_int_addr,
  input  logic [3:0]        m_int_byteen,
  output logic              interrupt,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              spurious_ack
);
  localparam int SW = PEND_W + 2;
  typedef enum logic [1:0] {IDLE, ASSERT, GAP_WAIT} state_t;
  state_t state, state_next;
  logic [31:0] cnt, last;
  logic [3:0] gap_cnt;
  logic [SW-1:0] sum;
  logic [PEND_W-1:0] pending_next;
  logic pev, ack, dec, sat, int_next;
  always_comb begin
    last = period > 32'd1 ? period - 32'd1 : '0;
    pev = period_en && cnt == last;
    ack = m_int_addr[31:2] == ACK_ADDR[31:2] && |m_int_byteen;
    dec = ack && state == ASSERT;
    // pending is always nonzero in ASSERT, so the ack decrement cannot underflow
    sum = SW'(pending) + SW'(pev) + SW'(trig) - SW'(dec);
    sat = sum > SW'({PEND_W{1'b1}});
    pending_next = sat ? '1 : sum[PEND_W-1:0];
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_next;
  always_comb
    state_next = state == IDLE   ? (pending_next != '0 ? ASSERT : IDLE) :
                 state == ASSERT ? (ack ? GAP_WAIT : ASSERT) :
                 gap_cnt > 4'd1  ? GAP_WAIT :
                 pending != '0   ? ASSERT : IDLE;
  always_comb
    int_next = state_next == ASSERT;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      gap_cnt      <= '0;
      pending      <= '0;
      overflow     <= 1'b0;
      spurious_ack <= 1'b0;
      interrupt    <= 1'b0;
    end else begin
      cnt          <= !period_en || pev ? '0 : cnt + 32'd1;
      gap_cnt      <= dec ? 4'(GAP) : state == GAP_WAIT && gap_cnt != 4'd0 ? gap_cnt - 4'd1 : gap_cnt;
      pending      <= pending_next;
      overflow     <= overflow | sat;
      spurious_ack <= ack && state != ASSERT;
      interrupt    <= int_next;
    end
  end
endmodule
